// File: rtl/spi_flash_reader_if.sv
// Wishbone-style register bus between spi_flash_reader (master) and an spi_master core (slave).
interface spi_flash_reader_if;
    logic       cyc_o;
    logic       stb_o;
    logic       we_o;
    logic [2:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/spi_flash_reader.sv
// Reads a block of SPI flash through an spi_master register core and streams the bytes out.
// Define SPI_FLASH_FAST_READ_EN to use the 0x0B fast-read command with one dummy byte.
module spi_flash_reader #(
    parameter int unsigned CS_INDEX = 0,
    parameter logic [1:0]  CLK_SPR  = 2'b00
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [23:0]               addr_i,
    input  logic [15:0]               len_i,
    output logic                      busy_o,
    output logic                      done_o,
    spi_flash_reader_if.master        wb,
    output logic [7:0]                data_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
    localparam logic [2:0] HDR_LAST = 3'd4;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
    localparam logic [2:0] HDR_LAST = 3'd3;
`endif

    typedef enum logic [3:0] {
        IDLE, CFG_SPCR, CFG_CS, HDR_WR, HDR_POLL, HDR_RD,
        DAT_WR, DAT_POLL, DAT_RD, DAT_OUT, CS_OFF, DONE
    } state_t;

    state_t      state_r, state_s;
    logic        cyc_r, cyc_s;
    logic        we_r, we_s;
    logic [2:0]  adr_r, adr_s;
    logic [7:0]  wdat_r, wdat_s;
    logic [23:0] addr_r, addr_s;
    logic [15:0] rem_r, rem_s;
    logic [2:0]  hdr_cnt_r, hdr_cnt_s;
    logic [7:0]  data_r, data_s;
    logic        valid_r, valid_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        acc_s;
    logic        req_we_s;
    logic [2:0]  req_adr_s;
    logic [7:0]  req_dat_s;
    logic        ack_s;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
        case (idx)
            3'd0:    hdr_byte = READ_CMD;
            3'd1:    hdr_byte = addr[23:16];
            3'd2:    hdr_byte = addr[15:8];
            3'd3:    hdr_byte = addr[7:0];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    // State and registered outputs; the bus strobe is only ever driven from cyc_r.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            adr_r     <= 3'd0;
            wdat_r    <= 8'h00;
            addr_r    <= 24'h000000;
            rem_r     <= 16'h0000;
            hdr_cnt_r <= 3'd0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            we_r      <= we_s;
            adr_r     <= adr_s;
            wdat_r    <= wdat_s;
            addr_r    <= addr_s;
            rem_r     <= rem_s;
            hdr_cnt_r <= hdr_cnt_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Next-state logic: each bus state issues one access, then advances on its ack.
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        we_s      = we_r;
        adr_s     = adr_r;
        wdat_s    = wdat_r;
        addr_s    = addr_r;
        rem_s     = rem_r;
        hdr_cnt_s = hdr_cnt_r;
        data_s    = data_r;
        valid_s   = valid_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        acc_s     = 1'b1;
        req_we_s  = 1'b0;
        req_adr_s = 3'd0;
        req_dat_s = 8'h00;
        ack_s     = cyc_r & wb.ack_i;

        case (state_r)
            CFG_SPCR: begin req_we_s = 1'b1; req_adr_s = 3'd0; req_dat_s = {6'b010100, CLK_SPR}; end
            CFG_CS:   begin req_we_s = 1'b1; req_adr_s = 3'd4; req_dat_s = 8'd1 << CS_INDEX; end
            HDR_WR:   begin req_we_s = 1'b1; req_adr_s = 3'd2; req_dat_s = hdr_byte(hdr_cnt_r, addr_r); end
            HDR_POLL, DAT_POLL: begin req_we_s = 1'b0; req_adr_s = 3'd1; end
            HDR_RD, DAT_RD:     begin req_we_s = 1'b0; req_adr_s = 3'd2; end
            DAT_WR:   begin req_we_s = 1'b1; req_adr_s = 3'd2; req_dat_s = 8'h00; end
            CS_OFF:   begin req_we_s = 1'b1; req_adr_s = 3'd4; req_dat_s = 8'h00; end
            default:  acc_s = 1'b0;
        endcase

        // Strobe drops on the ack edge, so the next access starts after one idle cycle.
        if (acc_s && !cyc_r) begin
            cyc_s  = 1'b1;
            we_s   = req_we_s;
            adr_s  = req_adr_s;
            wdat_s = req_dat_s;
        end else if (ack_s) begin
            cyc_s = 1'b0;
        end else begin
            cyc_s = cyc_r;
        end

        case (state_r)
            IDLE: begin
                if (start_i && len_i != 16'h0000) begin
                    state_s   = CFG_SPCR;
                    busy_s    = 1'b1;
                    addr_s    = addr_i;
                    rem_s     = len_i;
                    hdr_cnt_s = 3'd0;
                end else if (start_i) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CFG_SPCR: if (ack_s) state_s = CFG_CS;   else state_s = CFG_SPCR;
            CFG_CS:   if (ack_s) state_s = HDR_WR;   else state_s = CFG_CS;
            HDR_WR:   if (ack_s) state_s = HDR_POLL; else state_s = HDR_WR;
            HDR_POLL: if (ack_s && !wb.dat_i[0]) state_s = HDR_RD; else state_s = HDR_POLL;
            HDR_RD: begin
                if (ack_s) begin
                    hdr_cnt_s = hdr_cnt_r + 3'd1;
                    state_s   = (hdr_cnt_r == HDR_LAST) ? DAT_WR : HDR_WR;
                end else begin
                    state_s = HDR_RD;
                end
            end
            DAT_WR:   if (ack_s) state_s = DAT_POLL; else state_s = DAT_WR;
            DAT_POLL: if (ack_s && !wb.dat_i[0]) state_s = DAT_RD; else state_s = DAT_POLL;
            DAT_RD: begin
                if (ack_s) begin
                    data_s  = wb.dat_i;
                    valid_s = 1'b1;
                    state_s = DAT_OUT;
                end else begin
                    state_s = DAT_RD;
                end
            end
            DAT_OUT: begin
                if (ready_i) begin
                    valid_s = 1'b0;
                    rem_s   = rem_r - 16'd1;
                    state_s = (rem_r == 16'd1) ? CS_OFF : DAT_WR;
                end else begin
                    state_s = DAT_OUT;
                end
            end
            CS_OFF: begin
                if (ack_s) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = CS_OFF;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign wb.cyc_o = cyc_r;
    assign wb.stb_o = cyc_r;
    assign wb.we_o  = we_r;
    assign wb.adr_o = adr_r;
    assign wb.dat_o = wdat_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign data_o   = data_r;
    assign valid_o  = valid_r;

endmodule
